data_mem_responder: RTL

Single-port data memory responder that answers the core's data-memory request interface (request, we_re, mask, address, store data) and returns read data with a one-cycle valid pulse after a programmable number of wait states. It sits outside the core, driving `load_data_in` and `data_mem_valid`, and owns a byte-maskable word-addressed RAM array. It is the target used by system-level benches and the FPGA top.

---
 rtl/data_mem_responder.sv | 83 ++++++++
 1 files changed

// File: rtl/data_mem_responder.sv
// data_mem_responder: byte-maskable word RAM answering core data requests after LATENCY wait states.
// Ports: clk/rst (async active-high); request, we_re, mask, address, store_data from the core;
// load_data, valid (one-cycle response strobe), busy, error (out-of-range flag, coincident with valid).
// The access is performed on the edge that leaves RESP, so valid, error and load_data are registered
// and appear in the cycle after edge k+1+LATENCY for a request captured at edge k.
module data_mem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        request,
    input  logic        we_re,
    input  logic [3:0]  mask,
    input  logic [31:0] address,
    input  logic [31:0] store_data,
    output logic [31:0] load_data,
    output logic        valid,
    output logic        busy,
    output logic        error
);
    localparam int AW = $clog2(DEPTH_WORDS);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    state_t state, state_n;
    logic [3:0] cnt, cnt_n;
    logic cap_we;
    logic [3:0] cap_mask;
    logic [31:0] cap_addr, cap_data;
    logic [31:0] mem [DEPTH_WORDS];
    logic [AW-1:0] idx;
    logic oor, take, resp;
    assign idx = cap_addr[AW+1:2];
    assign oor = cap_addr >= 32'(4 * DEPTH_WORDS);
    assign resp = state == RESP;
    // RESP also accepts a new request so back-to-back accesses lose no cycle
    assign take = request && (state == IDLE || resp);
    // the response cycle itself follows RESP, so it is folded into busy via valid
    assign busy = state != IDLE || valid;
    always_comb begin
        state_n = state;
        cnt_n = cnt;
        if (take) begin
            cnt_n = 4'(LATENCY);
            state_n = LATENCY == 0 ? RESP : WAIT;
        end else if (resp) begin
            state_n = IDLE;
        end else if (state == WAIT) begin
            cnt_n = cnt - 4'd1;
            state_n = cnt == 4'd1 ? RESP : WAIT;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt <= '0;
            valid <= 1'b0;
            error <= 1'b0;
            load_data <= '0;
            cap_we <= 1'b0;
            cap_mask <= '0;
            cap_addr <= '0;
            cap_data <= '0;
        end else begin
            state <= state_n;
            cnt <= cnt_n;
            valid <= resp;
            error <= resp && oor;
            load_data <= (resp && !cap_we && !oor) ? mem[idx] : '0;
            if (take) begin
                cap_we <= we_re;
                cap_mask <= mask;
                cap_addr <= address;
                cap_data <= store_data;
            end
        end
    end
    // array has no reset so its contents survive rst
    always_ff @(posedge clk) begin
        if (resp && cap_we && !oor && !rst)
            for (int i = 0; i < 4; i++)
                if (cap_mask[i]) mem[idx][8*i +: 8] <= cap_data[8*i +: 8];
    end
endmodule
